iir_seq_ctrl: RTL

Sequencer that time-multiplexes one multiply-accumulate unit across NCH independent second-order IIR channels. It uses the same difference equation as the team's fully parallel biquad: y = B0·x + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2]. Each term is computed in its own cycle instead of with five parallel multipliers. It sits between a sample source and sink using valid/ready handshakes, and holds per-channel history internally.

---
 rtl/iir_pkg.sv | 29 ++
 rtl/iir_mac_unit.sv | 39 +++
 rtl/iir_seq_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// iir_pkg
//   Shared constants and types for the time-multiplexed biquad sequencer:
//   default coefficients, FSM state encoding, MAC step counter width and
//   the channel-index width helper.
//   Optional feature macro used by iir_seq_ctrl: IIR_SEQ_CLR_EN.
package iir_pkg;

    localparam int          IIR_NCH_DEF = 4;
    localparam logic [31:0] IIR_A1_DEF  = 32'd4;
    localparam logic [31:0] IIR_A2_DEF  = 32'd3;
    localparam logic [31:0] IIR_B0_DEF  = 32'd6;
    localparam logic [31:0] IIR_B1_DEF  = 32'd1;
    localparam logic [31:0] IIR_B2_DEF  = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } iir_state_e;

    localparam int                STEP_W    = 3;
    localparam logic [STEP_W-1:0] STEP_LAST = 3'd4;

    // Channel index width; a single channel would still need one bit.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// iir_mac_unit
//   One 32x32 multiplier truncated to 32 bits feeding an add/sub
//   accumulator. All arithmetic is unsigned modulo 2^32.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     clr          zero the accumulator on this edge
//     en           load acc_next into the accumulator on this edge
//     op_sub       0: acc + a*b, 1: acc - a*b
//     a, b         multiplier operands
//     acc          current accumulator value
//     acc_next     acc +/- a*b (combinational, used for the final step)
module iir_mac_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        op_sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] acc,
    output logic [31:0] acc_next
);

    logic [31:0] prod;

    assign prod     = a * b;
    assign acc_next = op_sub ? (acc - prod) : (acc + prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 32'd0;
        end else if (clr) begin
            acc <= 32'd0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/iir_seq_ctrl.sv
// iir_seq_ctrl
//   Runs NCH independent biquads
//     y = B0*x + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2]
//   through a single multiply-accumulate unit, one term per cycle.
//   Per-channel history lives in this module.
//   Optional macro IIR_SEQ_CLR_EN adds the clr_valid/clr_ch history clear.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid/in_ready     sample handshake, in_ch/in_x carry the sample
//     out_valid/out_ready   result handshake, out_ch/out_y carry the result
//     clr_valid, clr_ch     (IIR_SEQ_CLR_EN only) zero history of clr_ch
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for a sample
//   ST_MAC  | five MAC steps (0..4), writeback of history on step 4
//   ST_OUT  | out_valid=1, result held until out_ready
module iir_seq_ctrl
    import iir_pkg::*;
#(
    parameter int          NCH = IIR_NCH_DEF,
    parameter logic [31:0] A1  = IIR_A1_DEF,
    parameter logic [31:0] A2  = IIR_A2_DEF,
    parameter logic [31:0] B0  = IIR_B0_DEF,
    parameter logic [31:0] B1  = IIR_B1_DEF,
    parameter logic [31:0] B2  = IIR_B2_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [$clog2(NCH)-1:0] in_ch,
    input  logic [31:0]            in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic [31:0]            out_y
`ifdef IIR_SEQ_CLR_EN
    ,
    input  logic                   clr_valid,
    input  logic [$clog2(NCH)-1:0] clr_ch
`endif
);

    localparam int CW = ch_width(NCH);

    iir_state_e        state;
    logic [STEP_W-1:0] step;
    logic [CW-1:0]     ch_r;
    logic [31:0]       x_r;

    logic [31:0] xn1 [NCH];
    logic [31:0] xn2 [NCH];
    logic [31:0] yn1 [NCH];
    logic [31:0] yn2 [NCH];

    logic [31:0] coef;
    logic [31:0] operand;
    logic        op_sub;
    logic        mac_clr;
    logic        mac_en;
    logic        wb;
    logic [31:0] acc;
    logic [31:0] acc_next;

    // Gated by rst_n so the handshake reads not-ready while reset is held.
    assign in_ready  = rst_n && (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);

    assign mac_clr = (state == ST_IDLE) && in_valid;
    assign mac_en  = (state == ST_MAC);
    assign wb      = (state == ST_MAC) && (step == STEP_LAST);

    // Operand mux: history is read live, so a clear during MAC only
    // affects the steps that have not executed yet.
    always_comb begin
        coef    = 32'd0;
        operand = 32'd0;
        op_sub  = 1'b0;
        case (step)
            3'd0: begin coef = B0; operand = x_r;       end
            3'd1: begin coef = B1; operand = xn1[ch_r]; end
            3'd2: begin coef = B2; operand = xn2[ch_r]; end
            3'd3: begin coef = A1; operand = yn1[ch_r]; op_sub = 1'b1; end
            3'd4: begin coef = A2; operand = yn2[ch_r]; op_sub = 1'b1; end
            default: begin coef = 32'd0; operand = 32'd0; op_sub = 1'b0; end
        endcase
    end

    iir_mac_unit u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mac_clr),
        .en       (mac_en),
        .op_sub   (op_sub),
        .a        (coef),
        .b        (operand),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            step   <= '0;
            ch_r   <= '0;
            x_r    <= 32'd0;
            out_ch <= '0;
            out_y  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ch_r  <= in_ch;
                        x_r   <= in_x;
                        step  <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (step == STEP_LAST) begin
                        out_y  <= acc_next;
                        out_ch <= ch_r;
                        step   <= '0;
                        state  <= ST_OUT;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // History file. The clear is written after the step-4 writeback so it
    // takes priority when both hit the same channel on one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                xn1[i] <= 32'd0;
                xn2[i] <= 32'd0;
                yn1[i] <= 32'd0;
                yn2[i] <= 32'd0;
            end
        end else begin
            if (wb) begin
                xn2[ch_r] <= xn1[ch_r];
                xn1[ch_r] <= x_r;
                yn2[ch_r] <= yn1[ch_r];
                yn1[ch_r] <= acc_next;
            end
`ifdef IIR_SEQ_CLR_EN
            if (clr_valid) begin
                xn1[clr_ch] <= 32'd0;
                xn2[clr_ch] <= 32'd0;
                yn1[clr_ch] <= 32'd0;
                yn2[clr_ch] <= 32'd0;
            end
`endif
        end
    end

endmodule
